// File: rtl/drum_pkg.sv
// drum_pkg: shared helpers and payload types for the drum_pipe DRUM-k multiplier.
// Optional feature macro: DRUM_TWOS_COMP_EN selects true two's-complement negation
// (~x + 1). When it is undefined, negation is the legacy bitwise inversion (~x).
package drum_pkg;

  // Larger of two widths.
  function automatic int drum_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of the summed truncation shift: clog2(max(N, M)) + 1.
  function automatic int drum_shift_w(input int n, input int m);
    return $clog2(drum_max(n, m)) + 1;
  endfunction

  // Increment applied after inversion when negating a magnitude or a result.
`ifdef DRUM_TWOS_COMP_EN
  localparam logic DRUM_NEG_INC = 1'b1;
`else
  localparam logic DRUM_NEG_INC = 1'b0;
`endif

  // Width-independent per-transaction flags carried from S2 into S3.
  typedef struct packed {
    logic res_sign;
    logic approx;
  } drum_flags_t;

endpackage

// File: rtl/drum_trunc.sv
// drum_trunc: combinational DRUM operand reduction for one W-bit magnitude.
// Finds the leading one and keeps the K bits below and including it, forcing
// the LSB to 1 when lower bits were dropped.
module drum_trunc #(
  parameter int W  = 8,
  parameter int K  = 6,
  parameter int SW = 4
) (
  input  logic [W-1:0]  i_mag,
  output logic [K-1:0]  o_red,
  output logic [SW-1:0] o_shift,
  output logic          o_trunc
);

  localparam int PW = $clog2(W);

  logic [PW-1:0] w_pos;
  logic [SW-1:0] w_shamt;
  logic [K-1:0]  w_shifted;

  // Leading-one position; a zero magnitude reports position 0.
  always_comb begin
    // NOTE: the default before the loop keeps w_pos assigned on every path, so no latch is inferred.
    w_pos = '0;
    for (int i = 0; i < W; i++) begin
      if (i_mag[i]) w_pos = PW'(i);
    end
  end

  assign o_trunc   = (int'(w_pos) > K - 1);
  assign w_shamt   = o_trunc ? SW'(int'(w_pos) - (K - 1)) : '0;
  // Shifting right by t-(K-1) lands the leading one on bit K-1.
  assign w_shifted = K'(i_mag >> w_shamt);
  assign o_red     = o_trunc ? (w_shifted | K'(1)) : i_mag[K-1:0];
  assign o_shift   = w_shamt;

endmodule

// File: rtl/drum_pipe.sv
// drum_pipe: three-stage pipelined DRUM-k approximate multiplier with valid/ready.
// S1 sign/magnitude, S2 truncation, S3 multiply/shift/negate into the outputs.
// Optional feature macro: DRUM_TWOS_COMP_EN (true two's-complement negation).
module drum_pipe #(
  parameter int N = 8,
  parameter int M = 8,
  parameter int K = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [M-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+M-1:0] out_r,
  output logic           out_approx
);

  import drum_pkg::*;

  localparam int SW = drum_shift_w(N, M);
  localparam int RW = N + M;

  typedef struct packed {
    logic [N-1:0] mag_a;
    logic [M-1:0] mag_b;
    logic         res_sign;
  } s1_t;

  typedef struct packed {
    logic [K-1:0]  red_a;
    logic [K-1:0]  red_b;
    logic [SW-1:0] shift;
    drum_flags_t   flags;
  } s2_t;

  logic          r_v1, r_v2, r_out_valid;
  s1_t           r_s1;
  s2_t           r_s2;
  logic [RW-1:0] r_out_r;
  logic          r_out_approx;

  logic          w_en1, w_en2, w_en3;
  logic          w_sign_a, w_sign_b;
  logic [N-1:0]  w_mag_a;
  logic [M-1:0]  w_mag_b;
  logic [K-1:0]  w_red_a, w_red_b;
  logic [SW-1:0] w_sh_a, w_sh_b;
  logic          w_tr_a, w_tr_b;
  logic [2*K-1:0] w_prod_k;
  logic [RW-1:0] w_prod_sh;
  logic [RW-1:0] w_res;

  // Each stage loads when the stage after it is empty or emptying this cycle.
  assign w_en3    = !r_out_valid | out_ready;
  assign w_en2    = !r_v2 | w_en3;
  assign w_en1    = !r_v1 | w_en2;
  assign in_ready = w_en1;

  // S1 combinational: per-operand sign and unsigned magnitude.
  assign w_sign_a = in_signed & in_a[N-1];
  assign w_sign_b = in_signed & in_b[M-1];
  assign w_mag_a  = w_sign_a ? (~in_a + N'(DRUM_NEG_INC)) : in_a;
  assign w_mag_b  = w_sign_b ? (~in_b + M'(DRUM_NEG_INC)) : in_b;

  // S2 combinational: DRUM reduction of both magnitudes.
  drum_trunc #(.W(N), .K(K), .SW(SW)) u_trunc_a (
    .i_mag   (r_s1.mag_a),
    .o_red   (w_red_a),
    .o_shift (w_sh_a),
    .o_trunc (w_tr_a)
  );

  drum_trunc #(.W(M), .K(K), .SW(SW)) u_trunc_b (
    .i_mag   (r_s1.mag_b),
    .o_red   (w_red_b),
    .o_shift (w_sh_b),
    .o_trunc (w_tr_b)
  );

  // S3 combinational: K x K multiply, rescale, then restore the sign.
  assign w_prod_k  = (2*K)'(r_s2.red_a) * (2*K)'(r_s2.red_b);
  assign w_prod_sh = RW'(w_prod_k) << r_s2.shift;
  assign w_res     = r_s2.flags.res_sign ? (~w_prod_sh + RW'(DRUM_NEG_INC)) : w_prod_sh;

  // Stage valid flags; reset discards every in-flight entry.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, so stage order does not matter.
    if (rst) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_en1) r_v1        <= in_valid;
      if (w_en2) r_v2        <= r_v1;
      if (w_en3) r_out_valid <= r_v2;
    end
  end

  // S1 and S2 payload registers, loaded only with a valid upstream entry.
  always_ff @(posedge clk) begin
    // NOTE: payloads are not reset; the cleared valid flags already mark them as don't-care.
    if (w_en1 && in_valid) begin
      r_s1.mag_a    <= w_mag_a;
      r_s1.mag_b    <= w_mag_b;
      r_s1.res_sign <= w_sign_a ^ w_sign_b;
    end
    if (w_en2 && r_v1) begin
      r_s2.red_a          <= w_red_a;
      r_s2.red_b          <= w_red_b;
      r_s2.shift          <= w_sh_a + w_sh_b;
      r_s2.flags.res_sign <= r_s1.res_sign;
      r_s2.flags.approx   <= w_tr_a | w_tr_b;
    end
  end

  // Output data registers; cleared on reset and held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_r      <= '0;
      r_out_approx <= 1'b0;
    end else if (w_en3 && r_v2) begin
      r_out_r      <= w_res;
      r_out_approx <= r_s2.flags.approx;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_r      = r_out_r;
  assign out_approx = r_out_approx;

endmodule
